ttl_74259_clocked: RTL and testbench

TTL_74259_CLOCKED -- requirements
Module: ttl_74259_clocked

---
 rtl/ttl_74259_clocked.sv | 111 +++++++++++
 tb/tb_ttl_74259_clocked.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_74259_clocked.sv
// ttl_74259_clocked
//   Clocked addressable latch / demultiplexer with a built-in serial-fill pointer.
//   Every state change happens on the rising Clk edge; Clear_bar clears everything
//   asynchronously. Outputs leave the internal registers through one delayed
//   continuous assignment each.
//
// Ports
//   Clk        in   rising-edge clock
//   Clear_bar  in   asynchronous clear, active low
//   Enable_bar in   operation enable, active low
//   Mode       in   [1:0] operation select (see table below)
//   Select     in   [WIDTH_SELECT-1:0] bit index (write/demux) or pointer load value
//   D          in   data bit to route
//   Q          out  [WIDTH_OUT-1:0] registered outputs
//   Address    out  [WIDTH_SELECT-1:0] serial-fill pointer
//   Full       out  sticky flag, set when a fill writes the last index
//
// Mode | meaning
// -----+------------------------------------------------------------
//  00  | load pointer from Select (0 if out of range), clear Full
//  01  | Q[Select] <= D, other bits hold, clear Full
//  10  | Q[Select] <= D, other bits cleared, clear Full
//  11  | Q[Address] <= D, Address advances with wrap, Full is sticky
module ttl_74259_clocked #(
   parameter int WIDTH_OUT    = 16,
   parameter int WIDTH_SELECT = $clog2(WIDTH_OUT),
   parameter int DELAY_RISE   = 0,
   parameter int DELAY_FALL   = 0
) (
   input  logic                    Clk,
   input  logic                    Clear_bar,
   input  logic                    Enable_bar,
   input  logic [1:0]              Mode,
   input  logic [WIDTH_SELECT-1:0] Select,
   input  logic                    D,
   output logic [WIDTH_OUT-1:0]    Q,
   output logic [WIDTH_SELECT-1:0] Address,
   output logic                    Full
);

   localparam logic [1:0] MODE_LOAD  = 2'b00;
   localparam logic [1:0] MODE_WRITE = 2'b01;
   localparam logic [1:0] MODE_DEMUX = 2'b10;
   localparam logic [1:0] MODE_FILL  = 2'b11;

   localparam logic [31:0]             N_OUT     = 32'(WIDTH_OUT);
   localparam logic [WIDTH_SELECT-1:0] ADDR_LAST = WIDTH_SELECT'(WIDTH_OUT - 1);
   localparam logic [WIDTH_SELECT-1:0] ADDR_ONE  = WIDTH_SELECT'(1);

   logic [WIDTH_OUT-1:0]    q_reg;
   logic [WIDTH_SELECT-1:0] addr_reg;
   logic                    full_reg;

   logic                    sel_ok;
   logic                    at_last;
   logic [WIDTH_OUT-1:0]    demux_val;

   // Select can encode indices beyond the last output when WIDTH_OUT is not a
   // power of two; such indices must never touch Q.
   assign sel_ok  = 32'(Select) < N_OUT;
   assign at_last = (addr_reg == ADDR_LAST);

   always_comb begin
      demux_val = '0;
      if (sel_ok) demux_val[Select] = D;
   end

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         q_reg    <= '0;
         addr_reg <= '0;
         full_reg <= 1'b0;
      end else if (!Enable_bar) begin
         unique case (Mode)
            MODE_LOAD: begin
               addr_reg <= sel_ok ? Select : '0;
               full_reg <= 1'b0;
            end
            MODE_WRITE: begin
               if (sel_ok) q_reg[Select] <= D;
               full_reg <= 1'b0;
            end
            MODE_DEMUX: begin
               q_reg    <= demux_val;
               full_reg <= 1'b0;
            end
            MODE_FILL: begin
               // addr_reg is always in range, so no guard is needed here.
               q_reg[addr_reg] <= D;
               addr_reg        <= at_last ? '0 : addr_reg + ADDR_ONE;
               if (at_last) full_reg <= 1'b1;
            end
         endcase
      end
   end

   // The zero-delay case gets plain assignments so the default build carries
   // no timing constructs at all.
   generate
      if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_out_nodly
         assign Q       = q_reg;
         assign Address = addr_reg;
         assign Full    = full_reg;
      end else begin : g_out_dly
         assign #(DELAY_RISE, DELAY_FALL) Q       = q_reg;
         assign #(DELAY_RISE, DELAY_FALL) Address = addr_reg;
         assign #(DELAY_RISE, DELAY_FALL) Full    = full_reg;
      end
   endgenerate

endmodule

// File: tb/tb_ttl_74259_clocked.sv
// Bench for ttl_74259_clocked: a 16-output and a 10-output instance share all
// inputs; a bit-array model per instance predicts every output each cycle.
module tb_ttl_74259_clocked;

   logic       clk = 1'b0;
   logic       clear_bar, enable_bar, d;
   logic [1:0] mode;
   logic [3:0] sel;

   logic [15:0] q16;
   logic [3:0]  a16;
   logic        f16;
   logic [9:0]  q10;
   logic [3:0]  a10;
   logic        f10;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ttl_74259_clocked #(.WIDTH_OUT(16)) dut16 (
      .Clk(clk), .Clear_bar(clear_bar), .Enable_bar(enable_bar), .Mode(mode),
      .Select(sel), .D(d), .Q(q16), .Address(a16), .Full(f16)
   );

   ttl_74259_clocked #(.WIDTH_OUT(10)) dut10 (
      .Clk(clk), .Clear_bar(clear_bar), .Enable_bar(enable_bar), .Mode(mode),
      .Select(sel), .D(d), .Q(q10), .Address(a10), .Full(f10)
   );

   // model: index 0 -> 16-wide instance, index 1 -> 10-wide instance
   bit mq [2][16];
   int maddr [2];
   bit mfull [2];

   function automatic int nw(int k);
      return (k == 0) ? 16 : 10;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) mq[k][i] = 1'b0;
         maddr[k] = 0;
         mfull[k] = 1'b0;
      end
   endtask

   task automatic model_step(int k);
      int n;
      int s;
      n = nw(k);
      s = int'(sel);
      case (mode)
         2'd0: begin
            maddr[k] = (s < n) ? s : 0;
            mfull[k] = 1'b0;
         end
         2'd1: begin
            if (s < n) mq[k][s] = d;
            mfull[k] = 1'b0;
         end
         2'd2: begin
            for (int i = 0; i < n; i++) mq[k][i] = (i == s) ? d : 1'b0;
            mfull[k] = 1'b0;
         end
         default: begin
            mq[k][maddr[k]] = d;
            if (maddr[k] == n - 1) mfull[k] = 1'b1;
            maddr[k] = (maddr[k] + 1) % n;
         end
      endcase
   endtask

   always @(posedge clk or negedge clear_bar) begin
      if (!clear_bar) model_reset();
      else if (!enable_bar) begin
         model_step(0);
         model_step(1);
      end
   end

   function automatic logic [15:0] exp_q(int k);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < nw(k); i++) v[i] = mq[k][i];
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      logic [15:0] e0, e1;
      e0 = exp_q(0);
      e1 = exp_q(1);
      check("model_q16", 32'(q16), 32'(e0));
      check("model_addr16", 32'(a16), 32'(maddr[0]));
      check("model_full16", 32'(f16), 32'(mfull[0]));
      check("model_q10", 32'(q10), 32'(e1[9:0]));
      check("model_addr10", 32'(a10), 32'(maddr[1]));
      check("model_full10", 32'(f10), 32'(mfull[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   task automatic drive(logic [1:0] m, logic [3:0] s, logic dv);
      mode = m;
      sel  = s;
      d    = dv;
      tick();
   endtask

   task automatic reset_pulse();
      clear_bar = 1'b0;
      tick();
      clear_bar = 1'b1;
   endtask

   initial begin
      clear_bar  = 1'b0;
      enable_bar = 1'b0;
      mode       = 2'd0;
      sel        = 4'd0;
      d          = 1'b0;
      tick();
      check("reset_q16", 32'(q16), 32'h0);
      check("reset_addr16", 32'(a16), 32'h0);
      check("reset_full16", 32'(f16), 32'h0);
      check("reset_q10", 32'(q10), 32'h0);
      clear_bar = 1'b1;

      // addressable writes
      drive(2'd1, 4'd5, 1'b1);
      drive(2'd1, 4'd9, 1'b1);
      check("write_q16", 32'(q16), 32'h0220);
      check("write_addr16", 32'(a16), 32'h0);
      check("write_full16", 32'(f16), 32'h0);
      check("write_q10", 32'(q10), 32'h220);

      // demux
      drive(2'd2, 4'd3, 1'b1);
      check("demux_q16", 32'(q16), 32'h0008);
      drive(2'd2, 4'd3, 1'b0);
      check("demux_zero_q16", 32'(q16), 32'h0000);

      // pointer load then fill across the wrap
      reset_pulse();
      drive(2'd0, 4'd14, 1'b0);
      check("load_addr16", 32'(a16), 32'd14);
      check("load_oob_addr10", 32'(a10), 32'd0);
      drive(2'd3, 4'd0, 1'b1);
      check("fill1_full16", 32'(f16), 32'h0);
      drive(2'd3, 4'd0, 1'b1);
      check("fill2_full16", 32'(f16), 32'h1);
      check("fill2_addr16", 32'(a16), 32'd0);
      drive(2'd3, 4'd0, 1'b1);
      check("fill3_q16", 32'(q16), 32'hC001);
      check("fill3_addr16", 32'(a16), 32'd1);
      check("fill3_q10", 32'(q10), 32'h007);
      check("fill3_addr10", 32'(a10), 32'd3);

      // disabled edges change nothing
      enable_bar = 1'b1;
      for (int i = 0; i < 4; i++) drive((i % 2 == 0) ? 2'd3 : 2'd2, 4'(i), 1'(i));
      check("dis_q16", 32'(q16), 32'hC001);
      check("dis_addr16", 32'(a16), 32'd1);
      check("dis_full16", 32'(f16), 32'h1);
      enable_bar = 1'b0;
      drive(2'd1, 4'd0, 1'b1);
      check("en_write_full16", 32'(f16), 32'h0);
      check("en_write_q16", 32'(q16), 32'hC001);

      // async clear mid-fill
      reset_pulse();
      drive(2'd0, 4'd0, 1'b0);
      for (int i = 0; i < 7; i++) drive(2'd3, 4'd0, 1'b1);
      check("midfill_addr16", 32'(a16), 32'd7);
      #2 clear_bar = 1'b0;
      #1;
      check("async_q16", 32'(q16), 32'h0);
      check("async_addr16", 32'(a16), 32'h0);
      check("async_full16", 32'(f16), 32'h0);
      #1 clear_bar = 1'b1;
      drive(2'd3, 4'd0, 1'b1);
      check("after_clear_q16", 32'(q16), 32'h0001);

      // narrow instance: out-of-range write and wrapping fill
      reset_pulse();
      drive(2'd1, 4'd12, 1'b1);
      check("oob_write_q10", 32'(q10), 32'h0);
      check("oob_write_q16", 32'(q16), 32'h1000);
      drive(2'd0, 4'd0, 1'b0);
      for (int i = 1; i <= 11; i++) begin
         drive(2'd3, 4'd0, 1'b1);
         if (i == 9)  check("wrap9_addr10", 32'(a10), 32'd9);
         if (i == 10) check("wrap10_addr10", 32'(a10), 32'd0);
         if (i == 10) check("wrap10_full10", 32'(f10), 32'h1);
      end
      check("wrap11_addr10", 32'(a10), 32'd1);
      check("wrap11_full10", 32'(f10), 32'h1);
      check("wrap11_q10", 32'(q10), 32'h3FF);

      // randomized traffic, with occasional async clears between edges
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(63) == 0) begin
            #2 clear_bar = 1'b0;
            #2 clear_bar = 1'b1;
         end
         enable_bar = ($urandom_range(4) == 0);
         mode       = ($urandom_range(2) == 0) ? 2'd3 : 2'($urandom_range(3));
         sel        = 4'($urandom_range(15));
         d          = 1'($urandom_range(1));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
